// File: rtl/general_pkg.sv
// Project-wide constants shared by every block.
// Holds the asserted level of the reset input.
package general_pkg;

   localparam logic RESET_STATE = 1'b1;

endpackage

// File: rtl/hw_config_pkg.sv
// Data-memory geometry and shared types.
// The buffer state enum is also used by the read side.
package hw_config_pkg;

   localparam int N_BANKS         = 32;
   localparam int DATA_MEM_ADDR_L = 5;
   localparam int WORD_W          = 32;

   typedef logic [WORD_W-1:0]         word_t;
   typedef logic [WORD_W-1:0]         word_t_reg;
   typedef logic [N_BANKS*WORD_W-1:0] mem_word_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } buf_state_e;

endpackage

// File: rtl/data_mem_wr_buf.sv
// Coalesces single-word writes into one masked line write.
// Drains on a full line, an address change or flush_req.
module data_mem_wr_buf #(
   parameter int N_BANKS = hw_config_pkg::N_BANKS,
   parameter int ADDR_L  = hw_config_pkg::DATA_MEM_ADDR_L
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [ADDR_L-1:0]          in_addr,
   input  logic [$clog2(N_BANKS)-1:0] in_bank,
   input  hw_config_pkg::word_t       in_word,
   input  logic                       flush_req,
   output logic                       busy,
   output logic                       mem_wr_en,
   input  logic                       mem_wr_gnt,
   output logic [ADDR_L-1:0]          mem_wr_addr,
   output hw_config_pkg::mem_word_t   mem_wr_data,
   output logic [N_BANKS-1:0]         mem_wr_mask
);

   import hw_config_pkg::*;
   import general_pkg::*;

   buf_state_e          state_q;
   buf_state_e          state_d;
   logic [ADDR_L-1:0]   addr_q;
   logic [ADDR_L-1:0]   addr_d;
   logic [N_BANKS-1:0]  mask_q;
   logic [N_BANKS-1:0]  mask_d;
   logic [N_BANKS-1:0]  lane_sel;
   logic [N_BANKS-1:0]  mask_upd;
   logic                xfer;
   word_t_reg           line_q [N_BANKS];

   always_comb begin
      lane_sel          = '0;
      lane_sel[in_bank] = 1'b1;
   end

   // Ready never looks at in_vld, so the producer may test it first.
   always_comb begin
      in_rdy = 1'b0;
      unique case (state_q)
         EMPTY:   in_rdy = 1'b1;
         FILL:    in_rdy = (in_addr == addr_q);
         default: in_rdy = 1'b0;
      endcase
   end

   assign xfer     = in_vld && in_rdy;
   assign mask_upd = mask_q | (xfer ? lane_sel : '0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      unique case (state_q)
         EMPTY: begin
            if (xfer) begin
               addr_d  = in_addr;
               mask_d  = lane_sel;
               state_d = FILL;
            end
         end
         FILL: begin
            mask_d = mask_upd;
            if (&mask_upd || flush_req || (in_vld && !in_rdy))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (mem_wr_gnt) begin
               mask_d  = '0;
               state_d = EMPTY;
            end
         end
         default: begin
            mask_d  = '0;
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RESET_STATE) begin
         state_q <= EMPTY;
         addr_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
      end
   end

   // Line data is qualified by the mask, so it carries no reset.
   always_ff @(posedge clk) begin
      if (xfer)
         line_q[in_bank] <= in_word;
   end

   always_comb begin
      mem_wr_data = '0;
      for (int i = 0; i < N_BANKS; i++)
         mem_wr_data[i*WORD_W +: WORD_W] = line_q[i];
   end

   assign busy        = (state_q != EMPTY);
   assign mem_wr_en   = (state_q == DRAIN);
   assign mem_wr_addr = addr_q;
   assign mem_wr_mask = mask_q;

endmodule

// File: doc/data_mem_wr_buf.md
DATA_MEM_WR_BUF -- requirements
Module: data_mem_wr_buf

Interface
REQ-001 SHALL take parameter N_BANKS, default hw_config_pkg::N_BANKS, number of word lanes per data-memory line.
REQ-002 SHALL take parameter ADDR_L, default hw_config_pkg::DATA_MEM_ADDR_L, line-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_vld  in  1  write-word offer.
REQ-006 SHALL have port in_rdy  out  1  write-word acceptance.
REQ-007 SHALL have port in_addr  in  ADDR_L  target line address.
REQ-008 SHALL have port in_bank  in  $clog2(N_BANKS)  target lane in line.
REQ-009 SHALL have port in_word  in  word_t  write data.
REQ-010 SHALL have port flush_req  in  1  force drain of partial line.
REQ-011 SHALL have port busy  out  1  high whenever state is not EMPTY.
REQ-012 SHALL have port mem_wr_en  out  1  line write request to data memory.
REQ-013 SHALL have port mem_wr_gnt  in  1  memory accepts line write this cycle.
REQ-014 SHALL have port mem_wr_addr  out  ADDR_L  line address.
REQ-015 SHALL have port mem_wr_data  out  mem_word_t  line data.
REQ-016 SHALL have port mem_wr_mask  out  N_BANKS  per-lane write enable.

Function
REQ-017 SHALL implement FSM states EMPTY, FILL, DRAIN.
REQ-018 Word transfer SHALL occur exactly when in_vld && in_rdy on a rising edge.
REQ-019 in_rdy SHALL be 1 in EMPTY, 1 in FILL iff in_addr == held address, 0 in DRAIN; in_rdy depends combinationally on in_addr only, never on in_vld.
REQ-020 EMPTY + transfer: latch in_addr, write lane in_bank, set mask bit, go FILL.
REQ-021 FILL + transfer: write lane, set mask bit; same lane written twice SHALL keep last word.
REQ-022 FILL, in_vld=1, in_addr != held address: no transfer, go DRAIN next cycle.
REQ-023 FILL, mask all ones after this cycle's update: go DRAIN next cycle (word accepted at t gives mem_wr_en at t+1).
REQ-024 FILL + flush_req: go DRAIN; a coincident matching transfer SHALL be included in the drained line.
REQ-025 flush_req SHALL be ignored in EMPTY and DRAIN.
REQ-026 DRAIN: mem_wr_en=1 with stable addr/data/mask until mem_wr_gnt; on grant, clear mask, go EMPTY next cycle.
REQ-027 mem_wr_en SHALL be 0 outside DRAIN; mem_wr_data lanes with mask bit 0 are don't-care.
REQ-028 mem_wr_gnt SHALL be ignored outside DRAIN.
REQ-029 Every accepted word SHALL be written to memory exactly once; no loss, no duplication.

Reset
REQ-030 On rst: state EMPTY, mask 0, in_rdy 1, busy 0, mem_wr_en 0, mem_wr_addr 0, mem_wr_mask 0.
REQ-031 Reset mid-FILL or mid-DRAIN SHALL discard buffered data without issuing a write.
REQ-032 Line data storage SHALL use non-resettable word_t_reg flops; only control state and mask are reset.

Structure
REQ-033 word_t, word_t_reg, mem_word_t, N_BANKS, DATA_MEM_ADDR_L SHALL come from hw_config_pkg; RESET_STATE from general_pkg.
REQ-034 FSM state enum SHALL be defined in hw_config_pkg for reuse by the matching read-side block.
REQ-035 Single module, no sub-modules; line store is an N_BANKS-lane register array.

Verification (N_BANKS=32, ADDR_L=5)
REQ-036 32 words to addr 3, banks 0..31 back-to-back, gnt=1 -> one write at cycle after last accept, addr 3, mask 0xFFFFFFFF, data lane i = i.
REQ-037 Banks 2,5 to addr 7, then word to addr 8 -> in_rdy=0 for addr 8, write addr 7 mask 0x00000024, then addr 8 accepted.
REQ-038 Bank 4 twice to addr 1 (0xA then 0xB), flush_req -> mask 0x00000010, lane 4 = 0xB.
REQ-039 DRAIN with gnt held 0 for 10 cycles -> mem_wr_en, addr, data, mask stable; in_rdy=0 throughout; EMPTY one cycle after gnt.
REQ-040 rst asserted mid-FILL (3 words buffered) -> no mem_wr_en ever; busy=0 immediately; subsequent line writes correctly.
REQ-041 flush_req in EMPTY -> no write; flush_req with matching word same cycle -> that word appears in drained mask.
